// File: rtl/du_uart_arbiter.sv
// du_uart_arbiter
//
// Shares the debug unit's single UART byte channel (Rx FIFO read, Tx FIFO
// write, Tx start) among NUM_REQ sub-units. Index 0 is the master controller.
// A requester owns the channel from grant until it drops its request. Only
// the owner's strobes are registered onto the UART outputs. Only the owner
// sees the UART done pulses.
//
// Optional feature: define DU_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it, the lowest requesting index wins and no pointer is kept.
//
// Ports
//   clk          system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req        per-requester channel request (level)
//   i_rd         per-requester Rx FIFO read strobe
//   i_wr         per-requester Tx FIFO write strobe
//   i_tx_start   per-requester Tx start strobe
//   i_wdata      per-requester write data, slice k = [k*NB_UART_DATA +: NB_UART_DATA]
//   i_rx_done    UART Rx byte-done pulse
//   i_tx_done    UART Tx byte-done pulse
//   o_gnt        one-hot grant or zero
//   o_busy       channel owned
//   o_rd         registered UART read strobe
//   o_wr         registered UART write strobe
//   o_tx_start   registered UART Tx start strobe
//   o_wdata      registered UART write data
//   o_rx_done    Rx done routed to owner only
//   o_tx_done    Tx done routed to owner only
module du_uart_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned NB_UART_DATA = 8
) (
  input  logic                              clk,
  input  logic                              i_rst_n,
  input  logic [NUM_REQ-1:0]                i_req,
  input  logic [NUM_REQ-1:0]                i_rd,
  input  logic [NUM_REQ-1:0]                i_wr,
  input  logic [NUM_REQ-1:0]                i_tx_start,
  input  logic [NUM_REQ*NB_UART_DATA-1:0]   i_wdata,
  input  logic                              i_rx_done,
  input  logic                              i_tx_done,
  output logic [NUM_REQ-1:0]                o_gnt,
  output logic                              o_busy,
  output logic                              o_rd,
  output logic                              o_wr,
  output logic                              o_tx_start,
  output logic [NB_UART_DATA-1:0]           o_wdata,
  output logic [NUM_REQ-1:0]                o_rx_done,
  output logic [NUM_REQ-1:0]                o_tx_done
);

  localparam int unsigned OwnerW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGrant   = 2'd1,
    StRelease = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [OwnerW-1:0]       owner_q, owner_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    tx_start_q, tx_start_d;
  logic [NB_UART_DATA-1:0] wdata_q, wdata_d;

  logic                    win_found;
  logic [OwnerW-1:0]       win_idx;

`ifdef DU_ARB_ROUND_ROBIN_EN
  logic [OwnerW-1:0]       ptr_q, ptr_d;
  logic [OwnerW-1:0]       owner_next;

  // Owner + 1 modulo NUM_REQ; explicit wrap so non-power-of-2 counts work.
  assign owner_next = (owner_q == OwnerW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Search upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    int unsigned idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!win_found && i_req[idx]) begin
        win_found = 1'b1;
        win_idx   = OwnerW'(idx);
      end
    end
  end
`else
  // Fixed priority: walking downward leaves the lowest asserted index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        win_found = 1'b1;
        win_idx   = OwnerW'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    rd_d       = 1'b0;
    wr_d       = 1'b0;
    tx_start_d = 1'b0;
    wdata_d    = '0;
`ifdef DU_ARB_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          owner_d = win_idx;
          gnt_d   = NUM_REQ'(1) << win_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // Forwarded even on the edge the owner drops its request.
        rd_d       = i_rd[owner_q];
        wr_d       = i_wr[owner_q];
        tx_start_d = i_tx_start[owner_q];
        wdata_d    = i_wdata[32'(owner_q)*NB_UART_DATA +: NB_UART_DATA];
        gnt_d      = gnt_q;
        if (!i_req[owner_q]) begin
          gnt_d   = '0;
          state_d = StRelease;
`ifdef DU_ARB_ROUND_ROBIN_EN
          ptr_d   = owner_next;
`endif
        end
      end
      StRelease: begin
        // One idle cycle so two owners are never back-to-back.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      gnt_q      <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      tx_start_q <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      gnt_q      <= gnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      tx_start_q <= tx_start_d;
      wdata_q    <= wdata_d;
    end
  end

`ifdef DU_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign o_gnt      = gnt_q;
  assign o_busy     = (state_q == StGrant);
  assign o_rd       = rd_q;
  assign o_wr       = wr_q;
  assign o_tx_start = tx_start_q;
  assign o_wdata    = wdata_q;
  assign o_rx_done  = {NUM_REQ{i_rx_done}} & gnt_q;
  assign o_tx_done  = {NUM_REQ{i_tx_done}} & gnt_q;

endmodule

// File: tb/tb_du_uart_arbiter.sv
// Directed bench for du_uart_arbiter: a 4-requester instance for the main
// scenarios plus a 3-requester instance for pointer/priority wrap.
// Expectations follow DU_ARB_ROUND_ROBIN_EN when it is defined.
module tb_du_uart_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req, rd, wr, txs;
  logic [31:0] wdata;
  logic        rxd, txd;

  logic [3:0]  gnt, orxd, otxd;
  logic        busy, ord, owr, otx;
  logic [7:0]  owd;

  logic [2:0]  req3;
  logic [2:0]  gnt3, orxd3, otxd3;
  logic        busy3, ord3, owr3, otx3;
  logic [7:0]  owd3;

  int checks   = 0;
  int failures = 0;

  du_uart_arbiter #(.NUM_REQ(4), .NB_UART_DATA(8)) u_dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_rd       (rd),
    .i_wr       (wr),
    .i_tx_start (txs),
    .i_wdata    (wdata),
    .i_rx_done  (rxd),
    .i_tx_done  (txd),
    .o_gnt      (gnt),
    .o_busy     (busy),
    .o_rd       (ord),
    .o_wr       (owr),
    .o_tx_start (otx),
    .o_wdata    (owd),
    .o_rx_done  (orxd),
    .o_tx_done  (otxd)
  );

  du_uart_arbiter #(.NUM_REQ(3), .NB_UART_DATA(8)) u_dut3 (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_req      (req3),
    .i_rd       (3'b000),
    .i_wr       (3'b000),
    .i_tx_start (3'b000),
    .i_wdata    (24'h000000),
    .i_rx_done  (1'b0),
    .i_tx_done  (1'b0),
    .o_gnt      (gnt3),
    .o_busy     (busy3),
    .o_rd       (ord3),
    .o_wr       (owr3),
    .o_tx_start (otx3),
    .o_wdata    (owd3),
    .o_rx_done  (orxd3),
    .o_tx_done  (otxd3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Current owner drops (drop_req), request vector then becomes back_req
  // during the release cycle, next grant must be exp_gnt and hold 5 cycles.
  task automatic handover(input logic [3:0] drop_req, input logic [3:0] back_req,
                          input logic [3:0] exp_gnt, input string tag);
    req = drop_req;
    tick();
    check({tag, "_gap1"}, 32'(gnt), 32'h0);
    req = back_req;
    tick();
    check({tag, "_gap2"}, 32'(gnt), 32'h0);
    tick();
    check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    repeat (4) tick();
    check({tag, "_hold"}, 32'(gnt), 32'(exp_gnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req = '0; rd = '0; wr = '0; txs = '0; wdata = '0; rxd = 1'b0; txd = 1'b0;
    req3 = '0;
    #12;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_strobes", {29'h0, ord, owr, otx}, 32'h0);
    check("rst_wdata", 32'(owd), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_gnt", 32'(gnt), 32'h0);

    // Single request, then a write from the owner.
    req = 4'b0100;
    tick();
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_busy", 32'(busy), 32'h1);
    tick();
    tick();
    wr = 4'b0100;
    wdata[23:16] = 8'hA5;
    tick();
    check("single_wr", 32'(owr), 32'h1);
    check("single_wdata", 32'(owd), 32'hA5);
    rxd = 1'b1;
    #1;
    check("single_rxdone", 32'(orxd), 32'h4);
    rxd = 1'b0;
    wr = '0;
    wdata = '0;
    tick();
    check("single_wr_off", 32'(owr), 32'h0);
    req = '0;
    tick();
    check("single_rel_gnt", 32'(gnt), 32'h0);
    check("single_rel_busy", 32'(busy), 32'h0);
    tick();

    // Masking of a non-owner's strobes and done routing.
    req = 4'b0010;
    tick();
    check("mask_gnt", 32'(gnt), 32'h2);
    req = 4'b1010;
    txs = 4'b1000;
    wr  = 4'b1000;
    wdata[31:24] = 8'hFF;
    tick();
    check("mask_tx", 32'(otx), 32'h0);
    check("mask_wr", 32'(owr), 32'h0);
    check("mask_wdata", 32'(owd), 32'h0);
    check("mask_nopreempt", 32'(gnt), 32'h2);
    txs = '0;
    wr = '0;
    wdata = '0;
    txd = 1'b1;
    #1;
    check("mask_txdone", 32'(otxd), 32'h2);
    txd = 1'b0;
    handover(4'b1000, 4'b1000, 4'b1000, "mask_next");
    req = '0;
    tick();
    tick();

    // Contention between requesters 1 and 3.
    req = 4'b1010;
    tick();
    check("cont_first", 32'(gnt), 32'h2);
    repeat (4) tick();
`ifdef DU_ARB_ROUND_ROBIN_EN
    handover(4'b1000, 4'b1010, 4'b1000, "cont_h1");
    handover(4'b0010, 4'b1010, 4'b0010, "cont_h2");
    handover(4'b1000, 4'b1010, 4'b1000, "cont_h3");
    handover(4'b0010, 4'b0010, 4'b0010, "cont_h4");
`else
    handover(4'b1000, 4'b1010, 4'b0010, "cont_h1");
    handover(4'b1000, 4'b1010, 4'b0010, "cont_h2");
    handover(4'b1000, 4'b1010, 4'b0010, "cont_h3");
    handover(4'b1000, 4'b1000, 4'b1000, "cont_h4");
`endif
    req = '0;
    tick();
    tick();

    // Release boundary: strobe coincident with request drop.
    req = 4'b0001;
    tick();
    check("relb_gnt", 32'(gnt), 32'h1);
    tick();
    tick();
    req = 4'b0100;
    rd  = 4'b0001;
    tick();
    check("relb_rd", 32'(ord), 32'h1);
    check("relb_gnt0", 32'(gnt), 32'h0);
    rd = '0;
    tick();
    check("relb_gap", 32'(gnt), 32'h0);
    check("relb_rd_off", 32'(ord), 32'h0);
    tick();
    check("relb_next", 32'(gnt), 32'h4);
    req = '0;
    tick();
    tick();

    // Asynchronous reset in the middle of a grant.
    req = 4'b0001;
    tick();
    check("rstm_gnt", 32'(gnt), 32'h1);
    wr = 4'b0001;
    wdata[7:0] = 8'h3C;
    tick();
    check("rstm_wr", 32'(owr), 32'h1);
    check("rstm_wdata", 32'(owd), 32'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstm_async_gnt", 32'(gnt), 32'h0);
    check("rstm_async_busy", 32'(busy), 32'h0);
    check("rstm_async_wr", 32'(owr), 32'h0);
    check("rstm_async_wdata", 32'(owd), 32'h0);
    wr = '0;
    wdata = '0;
    req = 4'b0011;
    tick();
    check("rstm_held_gnt", 32'(gnt), 32'h0);
    check("rstm_held_wr", 32'(owr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rstm_regrant", 32'(gnt), 32'h1);
    req = '0;
    tick();
    tick();

    // Three-requester wrap: owner 2 releases with all requesting.
    req3 = 3'b100;
    tick();
    check("wrap_gnt2", 32'(gnt3), 32'h4);
    tick();
    req3 = 3'b011;
    tick();
    check("wrap_gap1", 32'(gnt3), 32'h0);
    req3 = 3'b111;
    tick();
    check("wrap_gap2", 32'(gnt3), 32'h0);
    tick();
    check("wrap_next", 32'(gnt3), 32'h1);
    req3 = '0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/du_uart_arbiter.md
# du_uart_arbiter

Arbitrates the single UART byte channel (Rx FIFO read, Tx FIFO write, Tx start) of the CPU debug unit between its sub-units: master controller, IMEM loader, regfile sender, DMEM sender. A requester owns the channel from grant until it drops its request; only the owner's strobes reach the UART. The owner's strobes are registered onto the UART outputs, and the owner alone sees UART completion flags. It sits between the debug sub-units and the UART/FIFO pair, in place of OR-combining their outputs.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8; index 0 = master controller.
- NB_UART_DATA, 8, UART data width.
- clk  in  1  system clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req  in  NUM_REQ  per-requester channel request; level, held for the whole transaction.
- i_rd  in  NUM_REQ  per-requester Rx FIFO read strobe.
- i_wr  in  NUM_REQ  per-requester Tx FIFO write strobe.
- i_tx_start  in  NUM_REQ  per-requester Tx start strobe.
- i_wdata  in  NUM_REQ*NB_UART_DATA  per-requester write data; requester k occupies bits [k*NB_UART_DATA +: NB_UART_DATA].
- i_rx_done  in  1  UART Rx byte-done pulse.
- i_tx_done  in  1  UART Tx byte-done pulse.
- o_gnt  out  NUM_REQ  one-hot grant, or all zero.
- o_busy  out  1  channel owned (state GRANT).
- o_rd, o_wr, o_tx_start  out  1  registered UART strobes.
- o_wdata  out  NB_UART_DATA  registered UART write data.
- o_rx_done, o_tx_done  out  NUM_REQ  done pulses routed to the owner only.

## Operation
- State machine with three states: IDLE, GRANT and RELEASE.
  - IDLE: if i_req != 0, select a winner, load owner index and o_gnt = onehot(winner), then go to GRANT. Otherwise remain in IDLE.
  - GRANT: o_busy = 1. If i_req[owner] = 0, clear o_gnt and go to RELEASE. Requests from other requesters are ignored; there is no preemption.
  - RELEASE: one cycle with o_gnt = 0, then go to IDLE. This is a mandatory gap so the channel is never granted to two requesters back-to-back.
- Forwarding, in GRANT only: o_rd/o_wr/o_tx_start <= i_rd/i_wr/i_tx_start[owner]; o_wdata <= owner slice of i_wdata.
- In IDLE and RELEASE, the strobe outputs and o_wdata are registered to 0.
- Strobes from non-owners are dropped, never queued.
- o_rx_done[k] = i_rx_done & o_gnt[k]; o_tx_done likewise. This path is combinational.
- Owner index width is $clog2(NUM_REQ). Round-robin pointer arithmetic wraps modulo NUM_REQ; for NUM_REQ not a power of 2, the pointer increments from NUM_REQ-1 to 0.

## Timing
- Reset values: state IDLE, o_gnt = 0, o_busy = 0, o_rd = o_wr = o_tx_start = 0, o_wdata = 0, round-robin pointer = 0. Because o_gnt = 0, o_rx_done = o_tx_done = 0.
- Reset asserted during GRANT: the grant is cleared immediately (asynchronously) and no strobe reaches the UART afterwards. After release, arbitration restarts with the pointer at 0.
- Request to grant: i_req sampled at edge k in IDLE gives o_gnt high after edge k.
- Strobe latency: an owner strobe present at edge k appears on o_* after edge k, high for exactly one cycle per cycle of input strobe.
- Release: i_req[owner] low at edge k gives o_gnt = 0 after edge k. The next grant is, at the earliest, after edge k+2.
- An owner strobe coincident with its own request drop at edge k is still forwarded.
- Simultaneous requests in IDLE are resolved by the priority rule (see Configuration).
- A request that is dropped before it is granted is lost without side effect.

## Configuration
- DU_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration: search from the pointer upward, wrapping.
  - On entry to RELEASE, pointer <= owner + 1 (mod NUM_REQ).
- Undefined:
  - Fixed priority: the lowest asserted index wins.
  - The pointer register is not implemented.

## Test plan
- Single request: i_req = 4'b0100 at edge 0 → o_gnt = 4'b0100 and o_busy = 1 after edge 0. i_wr[2] = 1 with slice 2 = 8'hA5 at edge 3 → o_wr = 1 and o_wdata = 8'hA5 for one cycle after edge 3.
- Masking: owner = 1, requester 3 pulses i_tx_start[3] and i_wr[3] → o_tx_start and o_wr stay 0. i_tx_done pulse → o_tx_done = 4'b0010 only.
- Contention: i_req = 4'b1010 held continuously, each owner dropping its request after 5 cycles of grant.
  - Fixed priority: grant order 1, 3 once requester 1 stops requesting; requester 1 wins again if it re-requests.
  - Round-robin: order 1, 3, 1, 3.
  - Each handover shows exactly 2 cycles of o_gnt = 0.
- Release boundary: owner drops i_req at edge 10 while pulsing i_rd → o_rd = 1 after edge 10, o_gnt = 0 after edge 10, new grant no earlier than after edge 12.
- Reset mid-grant: deassert i_rst_n mid-cycle while o_gnt = 4'b0001 and o_wr = 1 → all outputs go to 0 without waiting for a clock edge. After release with i_req = 4'b0011, round-robin grants 0 first.
- Wrap: NUM_REQ = 3, round-robin, owner 2 releases with i_req = 3'b111 → next grant = 0.
